// File: rtl/apb_timer_responder.sv
// APB3 completer for a 32-bit down-counting timer with external enable/clock
// input and a maskable, sticky interrupt. Zero wait states.
module apb_timer_responder (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic [11:2] paddr,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  ecorev,
  input  logic        extin,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        timerint
);

  localparam logic [9:0] ADDR_CTRL   = 10'h000;
  localparam logic [9:0] ADDR_VALUE  = 10'h001;
  localparam logic [9:0] ADDR_RELOAD = 10'h002;
  localparam logic [9:0] ADDR_INT    = 10'h003;
  localparam logic [9:0] ADDR_PID0   = 10'h3F8;
  localparam logic [9:0] ADDR_PID1   = 10'h3F9;
  localparam logic [9:0] ADDR_PID2   = 10'h3FA;
  localparam logic [9:0] ADDR_PID3   = 10'h3FB;

  logic [3:0]  ctrl;
  logic [31:0] value;
  logic [31:0] reload;
  logic        raw_int;
  logic        ext_meta;
  logic        ext_s;
  logic        ext_d;
  logic        ext_rise;
  logic        wr_en;
  logic        rd_setup;
  logic        ctrl_wr;
  logic        value_wr;
  logic        reload_wr;
  logic        int_clr;
  logic        int_set;
  logic        tick;

  function automatic logic addr_mapped(input logic [9:0] a);
    case (a)
      ADDR_CTRL, ADDR_VALUE, ADDR_RELOAD, ADDR_INT,
      ADDR_PID0, ADDR_PID1, ADDR_PID2, ADDR_PID3: addr_mapped = 1'b1;
      default:                                    addr_mapped = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] read_mux(input logic [9:0]  a,
                                           input logic [3:0]  c,
                                           input logic [31:0] v,
                                           input logic [31:0] r,
                                           input logic        ri,
                                           input logic [3:0]  eco);
    case (a)
      ADDR_CTRL:   read_mux = {28'h0, c};
      ADDR_VALUE:  read_mux = v;
      ADDR_RELOAD: read_mux = r;
      ADDR_INT:    read_mux = {31'h0, ri};
      ADDR_PID0:   read_mux = 32'h0000_0022;
      ADDR_PID1:   read_mux = 32'h0000_00B8;
      ADDR_PID2:   read_mux = 32'h0000_001B;
      ADDR_PID3:   read_mux = {24'h0, eco, 4'h0};
      default:     read_mux = 32'h0;
    endcase
  endfunction

  assign wr_en     = psel & penable & pwrite;
  assign rd_setup  = psel & ~penable & ~pwrite;
  assign ctrl_wr   = wr_en & (paddr == ADDR_CTRL);
  assign value_wr  = wr_en & (paddr == ADDR_VALUE);
  assign reload_wr = wr_en & (paddr == ADDR_RELOAD);
  assign int_clr   = wr_en & (paddr == ADDR_INT) & pwdata[0];

  assign ext_rise  = ext_s & ~ext_d;
  assign tick      = ctrl[0] & (~ctrl[1] | ext_s) & (~ctrl[2] | ext_rise);
  // A VALUE write on the same edge swallows the tick, including its interrupt.
  assign int_set   = tick & ~value_wr & (value == 32'd1);

  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~addr_mapped(paddr);

  // extin synchroniser and edge-detect history
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
      ext_d    <= 1'b0;
    end else begin
      ext_meta <= extin;
      ext_s    <= ext_meta;
      ext_d    <= ext_s;
    end
  end

  // register file, counter and interrupt
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl     <= 4'h0;
      value    <= 32'h0;
      reload   <= 32'h0;
      raw_int  <= 1'b0;
      timerint <= 1'b0;
      prdata   <= 32'h0;
    end else begin
      if (ctrl_wr)   ctrl   <= pwdata[3:0];
      if (reload_wr) reload <= pwdata;
      if (value_wr) begin
        value <= pwdata;
      end else if (tick) begin
        value <= (value > 32'd1) ? value - 32'd1 : reload;
      end
      if (int_set)      raw_int <= 1'b1;
      else if (int_clr) raw_int <= 1'b0;
      timerint <= raw_int & ctrl[3];
      if (rd_setup) prdata <= read_mux(paddr, ctrl, value, reload, raw_int, ecorev);
    end
  end

endmodule

// File: tb/tb_apb_timer_responder.sv
// Bench for apb_timer_responder: directed scenarios plus randomized APB/extin
// traffic, every output compared each cycle against a register-level model.
module tb_apb_timer_responder;

  logic        pclk;
  logic        presetn;
  logic        psel;
  logic [11:2] paddr;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  ecorev;
  logic        extin;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        timerint;

  int nvec;
  int nerr;
  logic chk_en;
  logic ext_rand;

  apb_timer_responder dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .ecorev(ecorev),
    .extin(extin), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .timerint(timerint)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus a history of sampled extin.
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] value;
    logic [31:0] reload;
    logic [31:0] rdata;
    logic        raw;
    logic        tint;
    logic [2:0]  hist;   // [0] extin at last edge, [1] two edges back, [2] three back
  } mdl_t;

  mdl_t m;

  function automatic logic ref_mapped(input logic [11:0] ba);
    return (ba == 12'h000) || (ba == 12'h004) || (ba == 12'h008) || (ba == 12'h00C) ||
           (ba == 12'hFE0) || (ba == 12'hFE4) || (ba == 12'hFE8) || (ba == 12'hFEC);
  endfunction

  function automatic logic [31:0] ref_read(input mdl_t s, input logic [11:0] ba, input logic [3:0] eco);
    case (ba)
      12'h000: return {28'h0, s.ctrl};
      12'h004: return s.value;
      12'h008: return s.reload;
      12'h00C: return {31'h0, s.raw};
      12'hFE0: return 32'h22;
      12'hFE4: return 32'hB8;
      12'hFE8: return 32'h1B;
      12'hFEC: return {24'h0, eco, 4'h0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic sel, input logic en, input logic wr,
                                input logic [11:0] ba, input logic [31:0] wd,
                                input logic [3:0] eco, input logic ext);
    mdl_t n;
    logic acc_wr;
    logic synced;
    logic rose;
    logic tk;
    n      = s;
    acc_wr = sel && en && wr;
    synced = s.hist[1];
    rose   = s.hist[1] && !s.hist[2];
    tk     = s.ctrl[0] && (!s.ctrl[1] || synced) && (!s.ctrl[2] || rose);
    if (sel && !en && !wr) n.rdata = ref_read(s, ba, eco);
    n.tint = s.raw && s.ctrl[3];
    if (acc_wr && ba == 12'h000) n.ctrl = wd[3:0];
    if (acc_wr && ba == 12'h008) n.reload = wd;
    if (acc_wr && ba == 12'h00C && wd[0]) n.raw = 1'b0;
    if (acc_wr && ba == 12'h004) begin
      n.value = wd;
    end else if (tk) begin
      if (s.value > 1) begin
        n.value = s.value - 1;
      end else begin
        n.value = s.reload;
        if (s.value == 1) n.raw = 1'b1;
      end
    end
    n.hist = {s.hist[1:0], ext};
    return n;
  endfunction

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) m <= '0;
    else          m <= step(m, psel, penable, pwrite, {paddr, 2'b00}, pwdata, ecorev, extin);
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("timerint", {31'h0, timerint}, {31'h0, m.tint});
      chk("prdata",   prdata, m.rdata);
      chk("pready",   {31'h0, pready}, 32'h1);
      chk("pslverr",  {31'h0, pslverr},
          {31'h0, psel && penable && !ref_mapped({paddr, 2'b00})});
    end
  end

  initial begin
    forever begin
      @(posedge pclk); #1;
      if (ext_rand && ($urandom_range(0, 3) == 0)) extin = ~extin;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic apb(input logic [11:0] ba, input logic w, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = ba[11:2]; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    rd = prdata; err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [11:0] ba, input logic [31:0] wd);
    logic [31:0] rd; logic err;
    apb(ba, 1'b1, wd, rd, err);
  endtask

  task automatic rd(input logic [11:0] ba, output logic [31:0] d, output logic err);
    apb(ba, 1'b0, 32'h0, d, err);
  endtask

  logic [31:0] d;
  logic        e;
  logic [11:0] amap [10];

  initial begin
    nvec = 0; nerr = 0; chk_en = 1'b0; ext_rand = 1'b0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    ecorev = 4'h5; extin = 1'b0; presetn = 1'b1;
    amap = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'hFE0,
             12'hFE4, 12'hFE8, 12'hFEC, 12'h010, 12'h0FC};
    #1 presetn = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_timerint", {31'h0, timerint}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    idle(3);
    presetn = 1'b1;
    idle(2);

    // reset / ID
    rd(12'hFEC, d, e); chk("pid3", d, 32'h50); chk("pid3_err", {31'h0, e}, 32'h0);
    rd(12'h000, d, e); chk("ctrl_rst", d, 32'h0); chk("ctrl_err", {31'h0, e}, 32'h0);

    // free-run with reload 3
    wr(12'h008, 32'd3);
    wr(12'h004, 32'd3);
    wr(12'h000, 32'h9);
    rd(12'h004, d, e); chk("free_v0", d, 32'd3);
    rd(12'h004, d, e); chk("free_v1", d, 32'd1);
    rd(12'h004, d, e); chk("free_v2", d, 32'd2);
    rd(12'h00C, d, e); chk("free_int", d, 32'h1);
    chk("free_timerint", {31'h0, timerint}, 32'h1);

    // clear racing against an interrupt-raising tick
    wr(12'h000, 32'h8);
    wr(12'h00C, 32'h1);
    wr(12'h004, 32'd2);
    idle(2);
    chk("race_pre_tint", {31'h0, timerint}, 32'h0);
    wr(12'h000, 32'h9);
    wr(12'h00C, 32'h1);
    rd(12'h00C, d, e); chk("race_raw", d, 32'h1);
    chk("race_timerint", {31'h0, timerint}, 32'h1);

    // external clock mode: four rising edges, last one held high
    wr(12'h000, 32'h0);
    wr(12'h00C, 32'h1);
    wr(12'h008, 32'h50);
    wr(12'h004, 32'd10);
    idle(4);
    wr(12'h000, 32'h5);
    repeat (3) begin extin = 1'b1; idle(4); extin = 1'b0; idle(4); end
    extin = 1'b1; idle(20);
    rd(12'h004, d, e); chk("extclk_value", d, 32'd6);
    extin = 1'b0;

    // VALUE write colliding with a tick at VALUE==1
    wr(12'h000, 32'h0);
    wr(12'h00C, 32'h1);
    wr(12'h004, 32'd2);
    wr(12'h000, 32'h1);
    wr(12'h004, 32'h100);
    rd(12'h004, d, e); chk("coll_value", d, 32'h100);
    rd(12'h00C, d, e); chk("coll_int", d, 32'h0);

    // error response on unmapped address
    apb(12'h010, 1'b1, 32'hFFFF_FFFF, d, e); chk("err_wr", {31'h0, e}, 32'h1);
    rd(12'h000, d, e); chk("err_ctrl_kept", d, 32'h1);
    rd(12'h010, d, e); chk("err_rd_data", d, 32'h0); chk("err_rd_err", {31'h0, e}, 32'h1);

    // reset during the access phase of a CTRL write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h000; pwdata = 32'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    idle(2);
    presetn = 1'b1;
    idle(1);
    rd(12'h000, d, e); chk("rst_mid_ctrl", d, 32'h0);
    rd(12'h004, d, e); chk("rst_mid_value", d, 32'h0);

    // randomized traffic, checked cycle-by-cycle against the model
    ext_rand = 1'b1;
    ecorev = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      logic [11:0] ba;
      logic        w;
      logic [31:0] wd;
      ba = amap[$urandom_range(0, 9)];
      w  = 1'($urandom_range(0, 1));
      if (ba == 12'h004 || ba == 12'h008) wd = 32'($urandom_range(0, 6));
      else                                 wd = $urandom;
      apb(ba, w, wd, d, e);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    ext_rand = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
